// File: rtl/matrix_row_sequencer_pkg.sv
// Shared constants, state encoding and helpers for matrix_row_sequencer.
package matseq_pkg;

  localparam int LANES    = 5;
  localparam int LANE_W   = 8;
  localparam int ROW_BITS = LANES * LANE_W;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MULR = 3'b011;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    EXE  = 3'd3,
    CAL  = 3'd4,
    WR   = 3'd5,
    DONE = 3'd6
  } state_t;

  // All-ones in every lane below size, zero above.
  function automatic logic [ROW_BITS-1:0] lane_mask(input logic [2:0] size);
    logic [ROW_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(size)) begin
        m[i*LANE_W +: LANE_W] = {LANE_W{1'b1}};
      end else begin
        m[i*LANE_W +: LANE_W] = {LANE_W{1'b0}};
      end
    end
    return m;
  endfunction

  function automatic logic cmd_legal(input logic [2:0] op, input logic [2:0] size);
    logic op_ok;
    case (op)
      OP_ADD, OP_SUB, OP_MULR, OP_CLR: op_ok = 1'b1;
      default:                         op_ok = 1'b0;
    endcase
    return op_ok && (size >= 3'd2) && (size <= 3'd5);
  endfunction

endpackage

// File: rtl/matrix_row_sequencer_if.sv
// Command, memory and ALU signals of matrix_row_sequencer; master = sequencer side.
interface matrix_row_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int ROW_W  = 40
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [2:0]        cmd_size;
  logic [ADDR_W-1:0] cmd_a_base;
  logic [ADDR_W-1:0] cmd_b_base;
  logic [ADDR_W-1:0] cmd_d_base;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [ROW_W-1:0]  mem_rd_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [ROW_W-1:0]  mem_wr_data;
  logic [2:0]        alu_op;
  logic [ROW_W-1:0]  alu_r1;
  logic [ROW_W-1:0]  alu_r2;
  logic [2:0]        alu_s;
  logic [ROW_W-1:0]  alu_res;
  logic              alu_ovf;
  logic              busy;
  logic              done;
  logic              ovf;
  logic              err;

  modport master (
    input  cmd_valid, cmd_op, cmd_size, cmd_a_base, cmd_b_base, cmd_d_base,
    input  mem_rd_data, alu_res, alu_ovf,
    output cmd_ready, mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data,
    output alu_op, alu_r1, alu_r2, alu_s, busy, done, ovf, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_size, cmd_a_base, cmd_b_base, cmd_d_base,
    output mem_rd_data, alu_res, alu_ovf,
    input  cmd_ready, mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data,
    input  alu_op, alu_r1, alu_r2, alu_s, busy, done, ovf, err
  );
endinterface

// File: rtl/matrix_row_sequencer.sv
// Row-by-row issue/writeback sequencer for element-wise matrix ops.
// Define MATSEQ_OVF_ABORT_EN to stop a command at the first overflowing row.
module matrix_row_sequencer
  import matseq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int ROW_W  = ROW_BITS
) (
  input logic                    clk,
  input logic                    rst_n,
  matrix_row_sequencer_if.master bus
);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d, size_q, size_d, r_q, r_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, d_base_q, d_base_d;
  logic [ROW_W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic              ovf_q, ovf_d, err_q, err_d;
  logic              cmd_ready_q, cmd_ready_d, busy_q, busy_d, done_q, done_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d, mem_wr_addr_q, mem_wr_addr_d;
  logic [ROW_W-1:0]  mem_wr_data_q, mem_wr_data_d;
  logic [2:0]        alu_op_q, alu_op_d, alu_s_q, alu_s_d;
  logic [ROW_W-1:0]  alu_r1_q, alu_r1_d, alu_r2_q, alu_r2_d;

  // Outputs are decoded from the next state so every one of them is a flop.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    size_d   = size_q;
    r_d      = r_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    d_base_d = d_base_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d     = bus.cmd_op;
          size_d   = bus.cmd_size;
          a_base_d = bus.cmd_a_base;
          b_base_d = bus.cmd_b_base;
          d_base_d = bus.cmd_d_base;
          r_d      = 3'd0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          if (!cmd_legal(bus.cmd_op, bus.cmd_size)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (bus.cmd_op == OP_CLR) begin
            res_d   = '0;
            state_d = WR;
          end else begin
            state_d = RDA;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RDA: state_d = RDB;
      RDB: begin
        a_d     = bus.mem_rd_data;
        state_d = EXE;
      end
      EXE: begin
        b_d     = bus.mem_rd_data;
        state_d = CAL;
      end
      CAL: begin
        res_d = bus.alu_res;
        ovf_d = ovf_q | bus.alu_ovf;
`ifdef MATSEQ_OVF_ABORT_EN
        if (bus.alu_ovf) begin
          state_d = DONE;
        end else begin
          state_d = WR;
        end
`else
        state_d = WR;
`endif
      end
      WR: begin
        if (r_q == size_q - 3'd1) begin
          state_d = DONE;
        end else begin
          r_d     = r_q + 3'd1;
          state_d = (op_q == OP_CLR) ? WR : RDA;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_ready_d   = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    mem_we_d      = 1'b0;
    mem_rd_addr_d = '0;
    mem_wr_addr_d = '0;
    mem_wr_data_d = '0;
    alu_op_d      = 3'd0;
    alu_s_d       = 3'd0;
    alu_r1_d      = '0;
    alu_r2_d      = '0;

    case (state_d)
      IDLE: cmd_ready_d = 1'b1;
      RDA: begin
        busy_d        = 1'b1;
        mem_rd_addr_d = a_base_d + ADDR_W'(r_d);
      end
      RDB: begin
        busy_d        = 1'b1;
        // Multiply-by-real takes its scalar from lane 0 of B's first word only.
        mem_rd_addr_d = (op_d == OP_MULR) ? b_base_d : b_base_d + ADDR_W'(r_d);
      end
      EXE: busy_d = 1'b1;
      CAL: begin
        busy_d   = 1'b1;
        alu_op_d = op_d;
        alu_s_d  = size_d;
        alu_r1_d = a_d;
        alu_r2_d = b_d;
      end
      WR: begin
        busy_d        = 1'b1;
        mem_we_d      = 1'b1;
        mem_wr_addr_d = d_base_d + ADDR_W'(r_d);
        mem_wr_data_d = res_d & ROW_W'(lane_mask(size_d));
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: cmd_ready_d = 1'b0;
    endcase
  end

  // Sequencer state, captured operands and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= 3'd0;
      size_q        <= 3'd0;
      r_q           <= 3'd0;
      a_base_q      <= '0;
      b_base_q      <= '0;
      d_base_q      <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      ovf_q         <= 1'b0;
      err_q         <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      alu_op_q      <= 3'd0;
      alu_s_q       <= 3'd0;
      alu_r1_q      <= '0;
      alu_r2_q      <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      size_q        <= size_d;
      r_q           <= r_d;
      a_base_q      <= a_base_d;
      b_base_q      <= b_base_d;
      d_base_q      <= d_base_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_q         <= res_d;
      ovf_q         <= ovf_d;
      err_q         <= err_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_we_q      <= mem_we_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      alu_op_q      <= alu_op_d;
      alu_s_q       <= alu_s_d;
      alu_r1_q      <= alu_r1_d;
      alu_r2_q      <= alu_r2_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ovf         = ovf_q;
  assign bus.err         = err_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_rd_addr = mem_rd_addr_q;
  assign bus.mem_wr_addr = mem_wr_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_s       = alu_s_q;
  assign bus.alu_r1      = alu_r1_q;
  assign bus.alu_r2      = alu_r2_q;

endmodule

// File: tb/tb_matrix_row_sequencer.sv
// Randomised self-checking bench for matrix_row_sequencer with memory, ALU stand-in
// and an arithmetic reference model of whole commands.
module tb_matrix_row_sequencer;
  import matseq_pkg::*;

  localparam int ADDR_W = 8;
  localparam int ROW_W  = 40;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [ROW_W-1:0] mem      [DEPTH];
  logic [ROW_W-1:0] init_mem [DEPTH];
  logic [ROW_W-1:0] exp_mem  [DEPTH];
  logic [8:0]       lane_r;

  always #5 clk = ~clk;

  matrix_row_sequencer_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) bus ();
  matrix_row_sequencer #(.ADDR_W(ADDR_W), .ROW_W(ROW_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Synchronous-read matrix memory.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_mem[i];
    end else if (bus.mem_we) begin
      mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    end
    bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  function automatic logic [8:0] lane_calc(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    case (op)
      OP_ADD:  p = {8'd0, x} + {8'd0, y};
      OP_SUB:  p = {8'd0, x} - {8'd0, y};
      OP_MULR: p = {8'd0, x} * {8'd0, y};
      default: p = 16'd0;
    endcase
    return {(op == OP_SUB) ? (x < y) : (p[15:8] != 8'd0), p[7:0]};
  endfunction

  // Lane ALU stand-in: combinational from the sequencer's alu_* outputs.
  always_comb begin
    bus.alu_res = '0;
    bus.alu_ovf = 1'b0;
    lane_r = 9'd0;
    for (int i = 0; i < LANES; i++) begin
      lane_r = lane_calc(bus.alu_op, bus.alu_r1[i*8 +: 8],
                         (bus.alu_op == OP_MULR) ? bus.alu_r2[7:0] : bus.alu_r2[i*8 +: 8]);
      bus.alu_res[i*8 +: 8] = lane_r[7:0];
      if (i < int'(bus.alu_s)) bus.alu_ovf = bus.alu_ovf | lane_r[8];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
    check_eq(tag, 64'(bad), 64'd0);
  endtask

  task automatic set_row(input int addr, input logic [ROW_W-1:0] val);
    init_mem[addr] = val;
    exp_mem[addr]  = val;
  endtask

  // Whole-command reference: updates exp_mem, returns latency, flags and activity counts.
  task automatic model_cmd(input logic [2:0] op, input logic [2:0] size, input int a, input int b,
                           input int d, input int max_rows, output int lat, output logic eovf,
                           output logic eerr, output int nwr, output int ncal);
    int s;
    logic [ROW_W-1:0] ra, rb, res;
    logic rovf;
    s = int'(size);
    eovf = 1'b0; eerr = 1'b0; nwr = 0; ncal = 0;
    if (!(op inside {3'd0, 3'd1, 3'd3, 3'd7}) || s < 2 || s > 5) begin
      eerr = 1'b1;
      lat  = 1;
      return;
    end
    if (op == 3'd7) begin
      lat = s + 1;
      for (int r = 0; r < s && r < max_rows; r++) begin
        exp_mem[(d + r) % DEPTH] = '0;
        nwr++;
      end
      return;
    end
    lat = 5 * s + 1;
    for (int r = 0; r < s && r < max_rows; r++) begin
      ra = exp_mem[(a + r) % DEPTH];
      rb = exp_mem[(op == 3'd3) ? b : (b + r) % DEPTH];
      res = '0;
      rovf = 1'b0;
      ncal++;
      for (int i = 0; i < s; i++) begin
        int x, y, v;
        x = int'(ra[i*8 +: 8]);
        y = (op == 3'd3) ? int'(rb[7:0]) : int'(rb[i*8 +: 8]);
        if (op == 3'd0) v = x + y;
        else if (op == 3'd1) v = x - y;
        else v = x * y;
        if (v < 0 || v > 255) rovf = 1'b1;
        res[i*8 +: 8] = 8'((v + 256) % 256);
      end
      eovf = eovf | rovf;
`ifdef MATSEQ_OVF_ABORT_EN
      if (rovf) begin
        lat = 5 * r + 5;
        return;
      end
`endif
      exp_mem[(d + r) % DEPTH] = res;
      nwr++;
    end
  endtask

  // Issue one command; rst_cycle > 0 pulls rst_n low at that cycle after accept.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] size,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                         input bit hold_junk, input int rst_cycle);
    int lat, nwr, ncal, cyc, we_cnt, busy_cnt, rdy_cnt, cal_cnt;
    logic eovf, eerr;
    bit seen_done;
    model_cmd(op, size, int'(a), int'(b), int'(d), (rst_cycle > 0) ? 1 : 8, lat, eovf, eerr, nwr, ncal);
    @(negedge clk);
    for (int k = 0; k < 50 && !bus.cmd_ready; k++) @(negedge clk);
    check_eq({tag, "_ready"}, 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_size = size;
    bus.cmd_a_base = a; bus.cmd_b_base = b; bus.cmd_d_base = d;
    @(posedge clk);
    #1;
    if (hold_junk) begin
      bus.cmd_op = OP_CLR; bus.cmd_size = 3'd5; bus.cmd_d_base = d + 8'd128;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    cyc = 0; seen_done = 1'b0; we_cnt = 0; busy_cnt = 0; rdy_cnt = 0; cal_cnt = 0;
    while (!seen_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rst_cycle > 0 && cyc == rst_cycle) begin
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_rst_outs"},
                 64'({bus.cmd_ready, bus.busy, bus.done, bus.mem_we, bus.ovf, bus.err,
                      bus.alu_s != 3'd0, bus.mem_rd_addr != 8'd0, bus.alu_r1 != 40'd0}),
                 64'b1_0000_0000);
        break;
      end
      we_cnt   += int'(bus.mem_we);
      busy_cnt += int'(bus.busy);
      rdy_cnt  += int'(bus.cmd_ready);
      cal_cnt  += int'(bus.alu_s != 3'd0);
      if (bus.done) seen_done = 1'b1;
    end
    bus.cmd_valid = 1'b0;
    check_eq({tag, "_writes"}, 64'(we_cnt), 64'(nwr));
    if (rst_cycle > 0) begin
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      check_eq({tag, "_latency"}, 64'(cyc), 64'(lat));
      check_eq({tag, "_busy"}, 64'(busy_cnt), 64'(lat));
      check_eq({tag, "_ready_busy"}, 64'(rdy_cnt), 64'd0);
      check_eq({tag, "_cal"}, 64'(cal_cnt), 64'(ncal));
      check_eq({tag, "_flags"}, 64'({bus.ovf, bus.err}), 64'({eovf, eerr}));
      @(negedge clk);
      check_eq({tag, "_after"}, 64'({bus.done, bus.cmd_ready, bus.ovf, bus.err}),
               64'({1'b0, 1'b1, eovf, eerr}));
    end
    check_mem({tag, "_mem"});
  endtask

  initial begin
    logic [2:0] op, size;
    int pick;
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_size = 3'd0;
    bus.cmd_a_base = 8'd0; bus.cmd_b_base = 8'd0; bus.cmd_d_base = 8'd0;
    for (int i = 0; i < DEPTH; i++) set_row(i, {8'($urandom), 32'($urandom)});
    set_row(16, 40'h0000030201); set_row(17, 40'h0101010101); set_row(18, 40'h0101010101);
    set_row(32, 40'h0000010101); set_row(33, 40'h0101010101); set_row(34, 40'h0101010101);
    set_row(64, 40'h0000000402); set_row(65, 40'h0000000101); set_row(80, 40'hFFFFFFFF03);
    set_row(112, 40'h0000000080); set_row(113, 40'h0000000001);
    set_row(120, 40'h0000000080); set_row(121, 40'h0000000001);
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check_eq("reset_outs",
             64'({bus.cmd_ready, bus.busy, bus.done, bus.mem_we, bus.ovf, bus.err,
                  bus.alu_op, bus.alu_s, bus.mem_wr_addr}),
             64'({1'b1, 5'b00000, 3'd0, 3'd0, 8'd0}));
    @(negedge clk);
    rst_n = 1'b1;

    run_cmd("add3", OP_ADD, 3'd3, 8'd16, 8'd32, 8'd48, 1'b0, 0);
    check_eq("add3_row0", 64'(mem[48]), 64'h0000040302);
    check_eq("add3_row2", 64'(mem[50]), 64'h0000020202);
    run_cmd("mulr2", OP_MULR, 3'd2, 8'd64, 8'd80, 8'd96, 1'b0, 0);
    check_eq("mulr_row0", 64'(mem[96]), 64'h0000000C06);
    check_eq("mulr_row1", 64'(mem[97]), 64'h0000000303);
    run_cmd("ovf2", OP_ADD, 3'd2, 8'd112, 8'd120, 8'd128, 1'b0, 0);
    check_eq("ovf_flag", 64'(bus.ovf), 64'd1);
`ifndef MATSEQ_OVF_ABORT_EN
    check_eq("ovf_row1", 64'(mem[129]), 64'h0000000002);
`endif
    run_cmd("bad_op", 3'b010, 3'd3, 8'd1, 8'd2, 8'd3, 1'b0, 0);
    run_cmd("bad_size", OP_ADD, 3'd6, 8'd1, 8'd2, 8'd3, 1'b0, 0);
    run_cmd("clr4", OP_CLR, 3'd4, 8'd0, 8'd0, 8'd144, 1'b0, 0);
    run_cmd("rst_mid", OP_ADD, 3'd5, 8'd160, 8'd176, 8'd192, 1'b0, 7);
    run_cmd("held", OP_SUB, 3'd2, 8'd200, 8'd210, 8'd220, 1'b1, 0);
    run_cmd("wrap", OP_SUB, 3'd4, 8'd254, 8'd253, 8'd255, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      pick = int'($urandom_range(0, 11));
      if (pick < 3) op = OP_ADD;
      else if (pick < 6) op = OP_SUB;
      else if (pick < 9) op = OP_MULR;
      else if (pick < 10) op = OP_CLR;
      else op = 3'($urandom);
      size = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(2, 5)) : 3'($urandom);
      run_cmd("rnd", op, size, 8'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
